// File: rtl/pwm_fade_sequencer_if.sv
// ---------------------------------------------------------------------------
// pwm_fade_sequencer_if
//   Bundles the CPU IO-bus slave port and the pwm write port of the fade
//   sequencer.
//   master : CPU-side agent; drives the cpu_* request and observes pwm_*.
//   slave  : the sequencer; accepts cpu_* and drives cpu_rdata and pwm_*.
//   cpu_sel/cpu_wstrb/cpu_addr/cpu_wdata : register access request
//   cpu_rdata                            : registered readback
//   pwm_sel/pwm_wstrb/pwm_wdata          : one-cycle duty write to the pwm
// ---------------------------------------------------------------------------
interface pwm_fade_sequencer_if;
   logic        cpu_sel;
   logic        cpu_wstrb;
   logic [1:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        pwm_sel;
   logic        pwm_wstrb;
   logic [31:0] pwm_wdata;

   modport master (
      output cpu_sel, cpu_wstrb, cpu_addr, cpu_wdata,
      input  cpu_rdata, pwm_sel, pwm_wstrb, pwm_wdata
   );

   modport slave (
      input  cpu_sel, cpu_wstrb, cpu_addr, cpu_wdata,
      output cpu_rdata, pwm_sel, pwm_wstrb, pwm_wdata
   );
endinterface

// File: rtl/pwm_fade_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_fade_sequencer
//   Owns the pwm write port and ramps the duty value one step at a time
//   toward a CPU-programmed target, either once or continuously between the
//   target and zero ("breathe").
//   clk    : system clock
//   resetn : synchronous reset, active low
//   bus    : CPU register port (TARGET, PERIOD, CTRL, STATUS) and pwm port
//   busy   : high whenever the sequencer is not parked in IDLE
// ---------------------------------------------------------------------------
module pwm_fade_sequencer #(
   parameter int DUTY_W  = 4,
   parameter int PRESC_W = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   pwm_fade_sequencer_if.slave  bus,
   output logic                 busy
);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_WRITE} state_t;

   state_t             state_q;
   logic [DUTY_W-1:0]  target_q;
   logic [PRESC_W-1:0] period_q;
   logic               en_q;
   logic               breathe_q;
   logic [DUTY_W-1:0]  duty_q;
   logic [PRESC_W-1:0] cnt_q;
   logic               goal_zero_q;   // breathe mode: currently heading to 0
   logic               pwm_stb_q;
   logic [DUTY_W-1:0]  pwm_duty_q;
   logic [31:0]        rdata_q;
   logic [31:0]        rdata_d;

   logic               cpu_wr;
   logic [DUTY_W-1:0]  goal;
   logic [DUTY_W-1:0]  goal_flip;
   logic [DUTY_W-1:0]  duty_step;
   logic [PRESC_W-1:0] cnt_limit;
   logic               unused_wdata;

   assign cpu_wr       = bus.cpu_sel & bus.cpu_wstrb;
   assign unused_wdata = ^bus.cpu_wdata[31:PRESC_W];

   assign goal      = (breathe_q && goal_zero_q) ? '0 : target_q;
   // Goal that breathe mode turns toward once the current one is reached.
   assign goal_flip = goal_zero_q ? target_q : '0;
   // The goal always lies inside [0, 2^DUTY_W-1], so stepping toward it can
   // never wrap; only called when duty_q != goal.
   assign duty_step = (goal > duty_q) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
   // PERIOD=0 behaves like PERIOD=1.
   assign cnt_limit = (period_q == '0) ? '0 : period_q - PRESC_W'(1);

   assign busy          = (state_q != ST_IDLE);
   assign bus.pwm_sel   = pwm_stb_q;
   assign bus.pwm_wstrb = pwm_stb_q;
   assign bus.pwm_wdata = {{(32-DUTY_W){1'b0}}, pwm_duty_q};
   assign bus.cpu_rdata = rdata_q;

   // Readback mux.
   always_comb begin
      // NOTE: default assignment first so every path drives rdata_d (no latch).
      rdata_d = '0;
      case (bus.cpu_addr)
         2'd0:    rdata_d[DUTY_W-1:0]  = target_q;
         2'd1:    rdata_d[PRESC_W-1:0] = period_q;
         2'd2:    rdata_d[1:0]         = {breathe_q, en_q};
         default: begin
            rdata_d[DUTY_W]     = busy;
            rdata_d[DUTY_W-1:0] = duty_q;
         end
      endcase
   end

   // CPU register file and registered readback.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!resetn) begin
         target_q  <= '0;
         period_q  <= '0;
         en_q      <= 1'b0;
         breathe_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (cpu_wr) begin
            case (bus.cpu_addr)
               2'd0:    target_q <= bus.cpu_wdata[DUTY_W-1:0];
               2'd1:    period_q <= bus.cpu_wdata[PRESC_W-1:0];
               2'd2: begin
                  en_q      <= bus.cpu_wdata[0];
                  breathe_q <= bus.cpu_wdata[1];
               end
               default: ;   // STATUS is read-only
            endcase
         end
         if (bus.cpu_sel) rdata_q <= rdata_d;
      end
   end

   // Ramp FSM with registered pwm strobe/data.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_INIT;
         duty_q      <= '0;
         cnt_q       <= '0;
         goal_zero_q <= 1'b0;
         pwm_stb_q   <= 1'b0;
         pwm_duty_q  <= '0;
      end else begin
         pwm_stb_q <= 1'b0;   // strobes last exactly one cycle
         case (state_q)
            ST_INIT: begin
               pwm_stb_q  <= 1'b1;
               pwm_duty_q <= '0;
               state_q    <= ST_IDLE;
            end
            ST_IDLE: begin
               if (en_q) begin
                  if (duty_q != goal) begin
                     cnt_q   <= '0;
                     state_q <= ST_WAIT;
                  end else if (breathe_q && goal_flip != duty_q) begin
                     goal_zero_q <= ~goal_zero_q;
                     cnt_q       <= '0;
                     state_q     <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!en_q || duty_q == goal) begin
                  // Disabled, or the goal was moved onto the current duty.
                  state_q <= ST_IDLE;
               end else if (cnt_q >= cnt_limit) begin
                  duty_q     <= duty_step;
                  pwm_duty_q <= duty_step;
                  pwm_stb_q  <= 1'b1;
                  state_q    <= ST_WRITE;
               end else begin
                  cnt_q <= cnt_q + PRESC_W'(1);
               end
            end
            ST_WRITE: begin
               cnt_q <= '0;
               if (!en_q) begin
                  state_q <= ST_IDLE;
               end else if (duty_q != goal) begin
                  state_q <= ST_WAIT;
               end else if (breathe_q && goal_flip != duty_q) begin
                  // Turn around without an idle cycle.
                  goal_zero_q <= ~goal_zero_q;
                  state_q     <= ST_WAIT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
Memory-mapped sequencer that owns the write port of the pwm LED driver and ramps its duty value toward a CPU-programmed target at a programmable step interval. It supports a one-shot ramp or a continuous "breathe" mode. It sits between the CPU IO bus decode and the pwm instance. The CPU never writes pwm directly; every pwm write is a one-cycle strobe issued by this block.

Parameters:
DUTY_W, 4, width of the duty value; full scale is 2^DUTY_W-1 (15).
PRESC_W, 16, width of the step-interval counter and the PERIOD register.

Ports:
clk  input  1  system clock
resetn  input  1  synchronous reset, active low
cpu_sel  input  1  block selected by the IO address decode
cpu_wstrb  input  1  CPU write strobe, qualified by cpu_sel
cpu_addr  input  2  register index: 0 TARGET, 1 PERIOD, 2 CTRL, 3 STATUS
cpu_wdata  input  32  CPU write data
cpu_rdata  output  32  register readback, registered
pwm_sel  output  1  select to pwm
pwm_wstrb  output  1  write strobe to pwm
pwm_wdata  output  32  duty to pwm, {zeros, duty}
busy  output  1  high while a ramp is in progress (state != IDLE)

Behaviour:
- Registers: TARGET[DUTY_W-1:0], PERIOD[PRESC_W-1:0], CTRL[1:0] (bit0 EN, bit1 BREATHE). STATUS (read-only) returns {busy, duty} in bits [DUTY_W] and [DUTY_W-1:0]. Writes to STATUS are ignored.
- A CPU write occurs when cpu_sel && cpu_wstrb, and takes effect on the next edge. cpu_rdata updates one cycle after cpu_sel with cpu_addr. Unused bits read 0.
- Reset (resetn=0 at an edge): TARGET=0, PERIOD=0, CTRL=0, duty=0, tick counter=0, pwm_sel=pwm_wstrb=0, pwm_wdata=0, cpu_rdata=0, state=INIT.
- FSM states: INIT, IDLE, WAIT, WRITE.
  - INIT: issue one pwm write of duty 0 (pwm_sel=pwm_wstrb=1 for exactly one cycle), then go to IDLE.
  - IDLE: if EN=1 and duty!=TARGET, go to WAIT and clear the counter. In BREATHE mode with duty==TARGET, the direction flips (see below) and the FSM also goes to WAIT.
  - WAIT: the counter increments each cycle. When counter >= max(PERIOD,1)-1, step duty by ±1 toward the current goal and go to WRITE. PERIOD=0 behaves as PERIOD=1, i.e. one step per cycle plus the write cycle.
  - WRITE: pwm_sel=pwm_wstrb=1 for one cycle with pwm_wdata={0,duty}. Then go to WAIT if duty != goal, otherwise go to IDLE.
- Goal: single mode uses goal=TARGET. BREATHE mode alternates the goal between TARGET and 0. On reaching the goal, the sequencer toggles and continues without returning through an extra idle cycle.
- Duty never wraps. Stepping saturates at 0 and at 2^DUTY_W-1, and TARGET bits above DUTY_W are dropped.
- TARGET or PERIOD written mid-ramp: the new value is used at the next WAIT comparison. If the new TARGET equals the current duty, the sequencer finishes at IDLE with no extra write.
- EN cleared mid-ramp: from WAIT, go to IDLE on the next edge with no write and duty retained. From WRITE, the write completes first, then the FSM goes to IDLE.
- pwm_wstrb is never high for two consecutive cycles. Outside WRITE and INIT, pwm_sel=pwm_wstrb=0 and pwm_wdata holds its last value.
- Reset asserted mid-operation aborts any strobe in the same edge, and the INIT write is re-issued after release.

Test Plan:
- Reset release: pwm_wstrb pulses once with pwm_wdata=0 in the first cycle after resetn rises, then busy=0 and no further strobes occur for 100 cycles.
- Single ramp: PERIOD=3, TARGET=5, EN=1 → 5 strobes with wdata 1,2,3,4,5, spaced 4 cycles apart (3 wait + 1 write); STATUS then reads busy=0, duty=5.
- Down ramp with PERIOD=0: TARGET=2 from duty=5 → strobes 4,3,2 on every second cycle; a later TARGET=20 saturates to 4 bits, so the ramp goes toward 4, not 20.
- Breathe: TARGET=3, PERIOD=1, CTRL=3 → repeating strobe sequence 1,2,3,2,1,0,1,2,3…; busy stays 1 throughout.
- Abort: EN cleared during WAIT at duty=2 → no further strobes, duty stays 2, busy=0 the next cycle. Re-enabling resumes from 2.
- Mid-ramp reset: resetn low for 1 cycle while ramping at duty=3 → the strobe in that cycle is suppressed, registers read 0, and the INIT write of 0 follows release.
